// File: rtl/imem_pkg.sv
// Shared constants, response-owner encoding and byte-to-word address helper for the imem arbiter.
package imem_pkg;

  localparam logic [31:0] IMEM_BASE  = 32'h8000_0000;
  localparam int unsigned IMEM_DEPTH = 255;
  localparam int unsigned IMEM_DW    = 32;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LOADER = 2'd2
  } imem_owner_e;

  // Registered response bookkeeping: who gets the response, and how to form its data.
  typedef struct packed {
    imem_owner_e owner;
    logic        err;
    logic        wr;
  } imem_rsp_t;

  // Word index of a byte address; addresses below the base wrap to large values.
  function automatic logic [31:0] imem_idx(input logic [31:0] addr,
                                           input logic [31:0] base = IMEM_BASE);
    imem_idx = (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Combinational byte-address translation and range/alignment check for one requester.
module imem_addr_check
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter logic [31:0] BASE_ADDR = IMEM_BASE
) (
  input  logic [31:0]   addr_i,
  output logic [AW-1:0] idx_o,
  output logic          err_o
);

  logic [31:0] idx_full;

  // Full-width index is compared so wrapped (below-base) addresses are caught.
  always_comb begin
    idx_full = imem_idx(addr_i, BASE_ADDR);
    idx_o    = idx_full[AW-1:0];
    err_o    = (addr_i[1:0] != 2'b00) || (idx_full >= 32'(DEPTH));
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: fetch has priority, loader is protected from
// starvation, responses return one cycle after acceptance to the requester that was granted.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH      = IMEM_DEPTH,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter logic [31:0] BASE_ADDR  = IMEM_BASE,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req_valid,
  output logic          f_req_ready,
  input  logic [31:0]   f_addr,
  output logic          f_rsp_valid,
  output logic [31:0]   f_rsp_data,
  output logic          f_rsp_err,
  input  logic          l_req_valid,
  output logic          l_req_ready,
  input  logic          l_req_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  input  logic          l_lock,
  output logic          l_rsp_valid,
  output logic [31:0]   l_rsp_data,
  output logic          l_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  imem_rsp_t     rsp_q, rsp_d;

  logic [AW-1:0] f_idx, l_idx;
  logic          f_err, l_err;
  logic          f_gnt, l_gnt;
  logic          sel_err, acc;
  logic [31:0]   rsp_data;

  imem_addr_check #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE_ADDR)) u_f_chk (
    .addr_i (f_addr),
    .idx_o  (f_idx),
    .err_o  (f_err)
  );

  imem_addr_check #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE_ADDR)) u_l_chk (
    .addr_i (l_addr),
    .idx_o  (l_idx),
    .err_o  (l_err)
  );

  // Grant: lock gives loader exclusive use, else fetch unless the loader is starved.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (l_lock) begin
        l_gnt = l_req_valid;
      end else if (f_req_valid && (starve_q < SW'(STARVE_MAX))) begin
        f_gnt = 1'b1;
      end else begin
        l_gnt = l_req_valid;
      end
    end
    f_req_ready = f_gnt;
    l_req_ready = l_gnt;
  end

  // Memory access, next response bookkeeping and starvation counter.
  always_comb begin
    sel_err   = l_gnt ? l_err : f_err;
    acc       = (f_gnt || l_gnt) && !sel_err;
    mem_en    = acc;
    mem_we    = acc && l_gnt && l_req_we;
    mem_addr  = acc ? (l_gnt ? l_idx : f_idx) : '0;
    mem_wdata = rst ? 32'h0 : l_wdata;

    rsp_d.owner = OWN_NONE;
    rsp_d.err   = 1'b0;
    rsp_d.wr    = 1'b0;
    if (f_gnt) begin
      rsp_d.owner = OWN_FETCH;
      rsp_d.err   = f_err;
    end else if (l_gnt) begin
      rsp_d.owner = OWN_LOADER;
      rsp_d.err   = l_err;
      rsp_d.wr    = l_req_we;
    end

    starve_d = '0;
    if (l_req_valid && !l_gnt) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
    end
  end

  // State registers with synchronous reset; a pending response is dropped by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q.owner <= OWN_NONE;
      rsp_q.err   <= 1'b0;
      rsp_q.wr    <= 1'b0;
      starve_q    <= '0;
    end else begin
      rsp_q    <= rsp_d;
      starve_q <= starve_d;
    end
  end

  // Response outputs: read data passes through only for an error-free read.
  always_comb begin
    f_rsp_valid = !rst && (rsp_q.owner == OWN_FETCH);
    l_rsp_valid = !rst && (rsp_q.owner == OWN_LOADER);
    rsp_data    = (!rsp_q.err && !rsp_q.wr) ? mem_rdata : 32'h0;
    f_rsp_data  = f_rsp_valid ? rsp_data : 32'h0;
    l_rsp_data  = l_rsp_valid ? rsp_data : 32'h0;
    f_rsp_err   = f_rsp_valid && rsp_q.err;
    l_rsp_err   = l_rsp_valid && rsp_q.err;
  end

endmodule
